// File: rtl/videogen_multi.sv
// videogen_multi
// ----------------------------------------------------------------------------
// Parametrised test-pattern and lag-test video source. A single pixel clock
// drives free-running h/v counters. Sync, data enable, RGB and a frame-start
// strobe are all registered from the same counter values, so every output is
// one cycle behind the counters and all outputs are aligned with each other.
//
// Optional feature (macro VIDEOGEN_SCROLL_EN):
//   defined   - an 8-bit frame counter scrolls the pattern 0 ramp by one grey
//               level per frame and rotates the pattern 1 bars by one bar
//               every 16 frames.
//   undefined - static patterns, no scroll counter.
//
// Ports:
//   clk27        in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   pattern_sel  in   0 ramp/border, 1 colour bars, 2 crosshatch, 3 white
//   lt_active    in   lag-test mode enable (overrides the pattern)
//   lt_mode      in   lag box position: 0 none, 1 top-left, 2 centre,
//                     3 bottom-right
//   R_out/G_out/B_out  out  8-bit colour, forced to 0 outside active area
//   HSYNC_out    out  horizontal sync, asserted level = HSYNC_POL
//   VSYNC_out    out  vertical sync, asserted level = VSYNC_POL
//   PCLK_out     out  copy of clk27
//   ENABLE_out   out  data enable (active area)
//   frame_start  out  one-cycle pulse with the first pixel of each frame
//
// The three control inputs are sampled only on the last pixel of a frame, so
// a change always takes effect cleanly at the next frame boundary.
// ----------------------------------------------------------------------------
module videogen_multi #(
  parameter int H_SYNCLEN       = 62,
  parameter int H_BACKPORCH     = 60,
  parameter int H_ACTIVE        = 720,
  parameter int H_TOTAL         = 858,
  parameter int V_SYNCLEN       = 6,
  parameter int V_BACKPORCH     = 30,
  parameter int V_ACTIVE        = 480,
  parameter int V_TOTAL         = 525,
  parameter int H_OVERSCAN      = 40,
  parameter int V_OVERSCAN      = 16,
  parameter int HSYNC_POL       = 0,
  parameter int VSYNC_POL       = 0,
  parameter int GRID_LOG2       = 5,
  parameter int LT_WIDTH        = 100,
  parameter int LT_HEIGHT       = 100,
  parameter int LT_FLASH_FRAMES = 0,
  parameter int CNT_W           = 11
) (
  input  logic       clk27,
  input  logic       reset_n,
  input  logic [1:0] pattern_sel,
  input  logic       lt_active,
  input  logic [1:0] lt_mode,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       HSYNC_out,
  output logic       VSYNC_out,
  output logic       PCLK_out,
  output logic       ENABLE_out,
  output logic       frame_start
);

  // Active-area geometry in counter coordinates.
  localparam int X_START = H_SYNCLEN + H_BACKPORCH;
  localparam int X_END   = X_START + H_ACTIVE;
  localparam int Y_START = V_SYNCLEN + V_BACKPORCH;
  localparam int Y_END   = Y_START + V_ACTIVE;

  // Centred 512x256 ramp window for pattern 0, in active coordinates. On a
  // raster smaller than the window the start goes negative and the whole
  // non-border area shows the ramp.
  localparam int WIN_X0 = (H_ACTIVE - 512) / 2;
  localparam int WIN_X1 = WIN_X0 + 512;
  localparam int WIN_Y0 = (V_ACTIVE - 256) / 2;
  localparam int WIN_Y1 = WIN_Y0 + 256;

  localparam int BAR_W     = H_ACTIVE / 8;
  localparam int GRID_MASK = (1 << GRID_LOG2) - 1;

  // Centred lag box bounds.
  localparam int LTC_X0 = H_ACTIVE / 2 - LT_WIDTH / 2;
  localparam int LTC_X1 = H_ACTIVE / 2 + LT_WIDTH / 2;
  localparam int LTC_Y0 = V_ACTIVE / 2 - LT_HEIGHT / 2;
  localparam int LTC_Y1 = V_ACTIVE / 2 + LT_HEIGHT / 2;

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             frame_end;

  // Controls latched at the frame boundary.
  logic [1:0] pat_sel_q;
  logic       lt_active_q;
  logic [1:0] lt_mode_q;

  logic       flash_phase;
  logic [7:0] scroll;

  // Next-output values derived from the current counters.
  int          h_i;
  int          v_i;
  int          x_i;
  int          y_i;
  logic        hs_n;
  logic        vs_n;
  logic        de_n;
  logic        fs_n;
  logic [7:0]  grey;
  logic [2:0]  bar;
  logic [2:0]  bar_rot;
  logic        box;
  logic [23:0] pat_rgb;

  assign PCLK_out  = clk27;
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) v_cnt <= '0;
      else                 v_cnt <= v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame-boundary control latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      pat_sel_q   <= 2'd0;
      lt_active_q <= 1'b0;
      lt_mode_q   <= 2'd0;
    end else if (frame_end) begin
      pat_sel_q   <= pattern_sel;
      lt_active_q <= lt_active;
      lt_mode_q   <= lt_mode;
    end
  end

  // --------------------------------------------------------------------------
  // Lag-box flash. The counter is held clear while lag mode is off so the
  // first lag frame always shows the box.
  // --------------------------------------------------------------------------
  generate
    if (LT_FLASH_FRAMES > 0) begin : g_flash
      localparam int FLASH_W = (LT_FLASH_FRAMES > 1) ? $clog2(LT_FLASH_FRAMES) : 1;
      localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(LT_FLASH_FRAMES - 1);

      logic [FLASH_W-1:0] flash_cnt;
      logic               phase_q;

      always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
          flash_cnt <= '0;
          phase_q   <= 1'b0;
        end else if (!lt_active_q) begin
          flash_cnt <= '0;
          phase_q   <= 1'b0;
        end else if (frame_end) begin
          if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            phase_q   <= ~phase_q;
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
          end
        end
      end

      assign flash_phase = phase_q;
    end else begin : g_steady
      assign flash_phase = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame scroll
  // --------------------------------------------------------------------------
`ifdef VIDEOGEN_SCROLL_EN
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n)       scroll <= 8'd0;
    else if (frame_end) scroll <= scroll + 8'd1;
  end
`else
  assign scroll = 8'd0;
`endif

  // Bar index (0 white .. 7 black) to {R,G,B}.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hffffff;
      3'd1:    c = 24'hffff00;
      3'd2:    c = 24'h00ffff;
      3'd3:    c = 24'h00ff00;
      3'd4:    c = 24'hff00ff;
      3'd5:    c = 24'hff0000;
      3'd6:    c = 24'h0000ff;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Pixel generation from the current counters
  // --------------------------------------------------------------------------
  always_comb begin
    h_i = int'(h_cnt);
    v_i = int'(v_cnt);
    x_i = h_i - X_START;
    y_i = v_i - Y_START;

    hs_n = (h_i < H_SYNCLEN) ? HS_ON : ~HS_ON;
    vs_n = (v_i < V_SYNCLEN) ? VS_ON : ~VS_ON;
    de_n = (h_i >= X_START) && (h_i < X_END) && (v_i >= Y_START) && (v_i < Y_END);
    fs_n = (h_cnt == '0) && (v_cnt == '0);

    grey    = 8'h00;
    bar     = 3'd0;
    box     = 1'b0;
    pat_rgb = 24'h000000;

    // Pattern 0: checkerboard border, flat grey surround, ramp window.
    if ((x_i < H_OVERSCAN) || (x_i >= H_ACTIVE - H_OVERSCAN) ||
        (y_i < V_OVERSCAN) || (y_i >= V_ACTIVE - V_OVERSCAN)) begin
      grey = (h_cnt[0] ^ v_cnt[0]) ? 8'hff : 8'h00;
    end else if ((x_i < WIN_X0) || (x_i >= WIN_X1) ||
                 (y_i < WIN_Y0) || (y_i >= WIN_Y1)) begin
      grey = 8'h50;
    end else begin
      grey = 8'((x_i - WIN_X0) >>> 1) + scroll;
    end

    // Pattern 1: bar boundaries are fixed multiples of BAR_W.
    for (int b = 1; b < 8; b++) begin
      if (x_i >= b * BAR_W) bar = 3'(b);
    end
    bar_rot = bar + scroll[6:4];

    case (lt_mode_q)
      2'd1: box = (x_i < LT_WIDTH) && (y_i < LT_HEIGHT);
      2'd2: box = (x_i >= LTC_X0) && (x_i < LTC_X1) && (y_i >= LTC_Y0) && (y_i < LTC_Y1);
      2'd3: box = (x_i >= H_ACTIVE - LT_WIDTH) && (y_i >= V_ACTIVE - LT_HEIGHT);
      default: box = 1'b0;
    endcase

    case (pat_sel_q)
      2'd0: pat_rgb = {grey, grey, grey};
      2'd1: pat_rgb = bar_colour(bar_rot);
      2'd2: pat_rgb = (((x_i & GRID_MASK) == 0) || ((y_i & GRID_MASK) == 0) ||
                       (x_i == H_ACTIVE - 1) || (y_i == V_ACTIVE - 1)) ? 24'hffffff : 24'h000000;
      default: pat_rgb = 24'hffffff;
    endcase

    if (lt_active_q) pat_rgb = (box && !flash_phase) ? 24'hffffff : 24'h000000;
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      HSYNC_out   <= HS_ON;
      VSYNC_out   <= VS_ON;
      ENABLE_out  <= 1'b0;
      R_out       <= 8'h00;
      G_out       <= 8'h00;
      B_out       <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      HSYNC_out   <= hs_n;
      VSYNC_out   <= vs_n;
      ENABLE_out  <= de_n;
      R_out       <= de_n ? pat_rgb[23:16] : 8'h00;
      G_out       <= de_n ? pat_rgb[15:8]  : 8'h00;
      B_out       <= de_n ? pat_rgb[7:0]   : 8'h00;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_videogen_multi.sv
// tb_videogen_multi
// Two instances on a reduced raster (80x48 total, 64x40 active) so that many
// frames fit in a short run: instance A with active-low syncs, instance B with
// active-high syncs. Both share clock, reset and controls. A pixel-level
// reference model pushes the expected output word of both instances into a
// queue for every counter position; the next cycle pops and compares it.
module tb_videogen_multi;

  localparam int HS = 4, HB = 6, HA = 64, HT = 80;
  localparam int VS = 2, VB = 3, VA = 40, VT = 48;
  localparam int HO = 8, VO = 4, GL = 3;
  localparam int LTW = 20, LTH = 10, LTF = 2;
  localparam int XS = HS + HB, YS = VS + VB;
  localparam int FRAME = HT * VT;
  localparam int WX0 = (HA - 512) / 2, WX1 = WX0 + 512;
  localparam int WY0 = (VA - 256) / 2, WY1 = WY0 + 256;

  // ---------------- clock / reset ----------------
  logic clk27 = 1'b0;
  always #5 clk27 = ~clk27;

  logic       reset_n;
  logic [1:0] pattern_sel;
  logic       lt_active;
  logic [1:0] lt_mode;

  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic a_hs, a_vs, a_pclk, a_de, a_fs;
  logic b_hs, b_vs, b_pclk, b_de, b_fs;

  videogen_multi #(
    .H_SYNCLEN(HS), .H_BACKPORCH(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNCLEN(VS), .V_BACKPORCH(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .H_OVERSCAN(HO), .V_OVERSCAN(VO), .HSYNC_POL(0), .VSYNC_POL(0),
    .GRID_LOG2(GL), .LT_WIDTH(LTW), .LT_HEIGHT(LTH), .LT_FLASH_FRAMES(LTF), .CNT_W(11)
  ) u_dut_a (
    .clk27(clk27), .reset_n(reset_n), .pattern_sel(pattern_sel),
    .lt_active(lt_active), .lt_mode(lt_mode),
    .R_out(a_r), .G_out(a_g), .B_out(a_b), .HSYNC_out(a_hs), .VSYNC_out(a_vs),
    .PCLK_out(a_pclk), .ENABLE_out(a_de), .frame_start(a_fs)
  );

  videogen_multi #(
    .H_SYNCLEN(HS), .H_BACKPORCH(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNCLEN(VS), .V_BACKPORCH(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .H_OVERSCAN(HO), .V_OVERSCAN(VO), .HSYNC_POL(1), .VSYNC_POL(1),
    .GRID_LOG2(GL), .LT_WIDTH(LTW), .LT_HEIGHT(LTH), .LT_FLASH_FRAMES(LTF), .CNT_W(11)
  ) u_dut_b (
    .clk27(clk27), .reset_n(reset_n), .pattern_sel(pattern_sel),
    .lt_active(lt_active), .lt_mode(lt_mode),
    .R_out(b_r), .G_out(b_g), .B_out(b_b), .HSYNC_out(b_hs), .VSYNC_out(b_vs),
    .PCLK_out(b_pclk), .ENABLE_out(b_de), .frame_start(b_fs)
  );

  // ---------------- scoreboard state ----------------
  logic [55:0] exp_q[$];
  int          tag_q[$];
  int compared = 0;
  int mismatched = 0;
  bit abort = 0;

  // Reference model state (mirrors what the bench has driven).
  int         m_h, m_v, m_fcnt;
  logic [1:0] m_pat, m_ltm;
  logic       m_lta, m_phase;
  logic [7:0] m_scroll;
  int         last_h, last_v;

  int cnt_hs, cnt_vs, cnt_de, cnt_fs, cnt_hsb;

  logic [23:0] bar_tab [0:7] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                 24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

  // {hs, vs, de, rgb, fs} for instance A at raster position (h, v).
  function automatic logic [27:0] model_px(input int h, input int v);
    int x, y, idx;
    logic hs, vs, de, fs, box;
    logic [7:0] g;
    logic [23:0] rgb;
    x = h - XS;
    y = v - YS;
    hs = (h >= HS);
    vs = (v >= VS);
    de = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    fs = (h == 0) && (v == 0);
    rgb = 24'h0;
    if (de) begin
      if (m_lta) begin
        box = 1'b0;
        if (m_ltm == 2'd1) box = (x < LTW) && (y < LTH);
        if (m_ltm == 2'd2) box = (x >= HA/2 - LTW/2) && (x < HA/2 + LTW/2) &&
                                 (y >= VA/2 - LTH/2) && (y < VA/2 + LTH/2);
        if (m_ltm == 2'd3) box = (x >= HA - LTW) && (y >= VA - LTH);
        rgb = (box && !m_phase) ? 24'hffffff : 24'h0;
      end else begin
        case (m_pat)
          2'd0: begin
            if (x < HO || x >= HA - HO || y < VO || y >= VA - VO)
              g = ((h + v) % 2 == 1) ? 8'hff : 8'h00;
            else if (x < WX0 || x >= WX1 || y < WY0 || y >= WY1)
              g = 8'h50;
            else
              g = 8'((x - WX0) / 2) + m_scroll;
            rgb = {g, g, g};
          end
          2'd1: begin
            idx = (x / (HA / 8) + int'(m_scroll[6:4])) % 8;
            rgb = bar_tab[idx];
          end
          2'd2: rgb = (x % (1 << GL) == 0 || y % (1 << GL) == 0 || x == HA-1 || y == VA-1)
                      ? 24'hffffff : 24'h0;
          default: rgb = 24'hffffff;
        endcase
      end
    end
    return {hs, vs, de, rgb, fs};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_fcnt = 0; m_phase = 0;
    m_pat = 0; m_lta = 0; m_ltm = 0; m_scroll = 0;
    exp_q.delete();
    tag_q.delete();
  endtask

  task automatic model_advance();
    bit fe;
    fe = (m_h == HT-1) && (m_v == VT-1);
    if (!m_lta) begin
      m_fcnt = 0; m_phase = 0;
    end else if (fe) begin
      if (m_fcnt == LTF-1) begin m_fcnt = 0; m_phase = !m_phase; end
      else m_fcnt++;
    end
    if (fe) begin
      m_pat = pattern_sel; m_lta = lt_active; m_ltm = lt_mode;
`ifdef VIDEOGEN_SCROLL_EN
      m_scroll = m_scroll + 8'd1;
`endif
    end
    if (m_h == HT-1) begin
      m_h = 0;
      m_v = (m_v == VT-1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
  endtask

  // One clock: push expectation for the current counters, then compare the
  // registered outputs one edge later.
  task automatic cycle();
    logic [27:0] pa;
    logic [55:0] e, act;
    int tag;
    pa = model_px(m_h, m_v);
    exp_q.push_back({pa, pa ^ {2'b11, 26'd0}});
    tag_q.push_back(m_h * 10000 + m_v);
    last_h = m_h; last_v = m_v;
    model_advance();
    @(negedge clk27);
    if (!a_hs) cnt_hs++;
    if (!a_vs) cnt_vs++;
    if (a_de)  cnt_de++;
    if (a_fs)  cnt_fs++;
    if (b_hs)  cnt_hsb++;
    act = {a_hs, a_vs, a_de, a_r, a_g, a_b, a_fs, b_hs, b_vs, b_de, b_r, b_g, b_b, b_fs};
    e = exp_q.pop_front();
    tag = tag_q.pop_front();
    if (!abort) begin
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL pixel h=%0d v=%0d got=%h expected=%h", tag / 10000, tag % 10000, act, e);
        if (mismatched >= 30) abort = 1;
      end
    end
  endtask

  // Run until the output for counter position (h, v) is on the DUT pins.
  task automatic wait_px(input int h, input int v);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(last_h == h && last_v == v) && n < 2*FRAME + 4);
    if (!(last_h == h && last_v == v)) begin
      compared++; mismatched++;
      $display("FAIL wait_px_timeout h=%0d v=%0d got=timeout expected=reached", h, v);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    pattern_sel = 0; lt_active = 0; lt_mode = 0;
    @(negedge clk27);
    reset_n = 1'b0;
    #1;
    compared++;
    if ({a_hs, a_vs, a_de, a_r, a_g, a_b, a_fs, b_hs, b_vs, b_de, b_r, b_g, b_b, b_fs}
        !== {28'd0, 2'b11, 26'd0}) begin
      mismatched++;
      $display("FAIL reset_values got=%h expected=%h",
               {a_hs, a_vs, a_de, a_r, a_g, a_b, a_fs, b_hs, b_vs, b_de, b_r, b_g, b_b, b_fs},
               {28'd0, 2'b11, 26'd0});
    end
    repeat (3) @(negedge clk27);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sync_timing();
    int n;
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0; cnt_hsb = 0;
    repeat (FRAME) cycle();
    compared++;
    if (cnt_hs != HS*VT) begin mismatched++; $display("FAIL hsync_low_cycles got=%0d expected=%0d", cnt_hs, HS*VT); end
    compared++;
    if (cnt_vs != VS*HT) begin mismatched++; $display("FAIL vsync_low_cycles got=%0d expected=%0d", cnt_vs, VS*HT); end
    compared++;
    if (cnt_de != HA*VA) begin mismatched++; $display("FAIL enable_cycles got=%0d expected=%0d", cnt_de, HA*VA); end
    compared++;
    if (cnt_fs != 1) begin mismatched++; $display("FAIL frame_start_count got=%0d expected=1", cnt_fs); end
    compared++;
    if (cnt_hsb != HS*VT) begin mismatched++; $display("FAIL hsync_pol1_high_cycles got=%0d expected=%0d", cnt_hsb, HS*VT); end
    // frame_start period
    n = 0;
    do begin cycle(); n++; end while (!a_fs && n < FRAME + 2);
    n = 0;
    do begin cycle(); n++; end while (!a_fs && n < FRAME + 2);
    compared++;
    if (n != FRAME) begin mismatched++; $display("FAIL frame_start_period got=%0d expected=%0d", n, FRAME); end
  endtask

  task automatic test_ramp_border();
    logic [7:0] g;
    wait_px(XS, YS);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL checker_x0 got=%h expected=ffffff", {a_r, a_g, a_b}); end
    wait_px(XS+1, YS);
    compared++;
    if ({a_r, a_g, a_b} !== 24'h000000) begin mismatched++; $display("FAIL checker_x1 got=%h expected=000000", {a_r, a_g, a_b}); end
    wait_px(XS+HO, YS+VO);
    g = 8'h74 + m_scroll;
    compared++;
    if ({a_r, a_g, a_b} !== {g, g, g}) begin mismatched++; $display("FAIL ramp_first got=%h expected=%h", {a_r, a_g, a_b}, {g, g, g}); end
  endtask

  task automatic test_switch_bars();
    logic [7:0] g;
    wait_px(XS, YS+20);
    pattern_sel = 2'd1;
    wait_px(XS+20, YS+30);
    g = 8'h7a + m_scroll;
    compared++;
    if ({a_r, a_g, a_b} !== {g, g, g}) begin mismatched++; $display("FAIL no_midframe_switch got=%h expected=%h", {a_r, a_g, a_b}, {g, g, g}); end
    wait_px(0, 0);
    compared++;
    if ({a_fs, a_de, a_r, a_g, a_b} !== {2'b10, 24'h0}) begin
      mismatched++; $display("FAIL blank_rgb_fs got=%h expected=%h", {a_fs, a_de, a_r, a_g, a_b}, {2'b10, 24'h0});
    end
    wait_px(XS, YS);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL bar_x0 got=%h expected=ffffff", {a_r, a_g, a_b}); end
    wait_px(XS+HA/8, YS);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffff00) begin mismatched++; $display("FAIL bar_x_w got=%h expected=ffff00", {a_r, a_g, a_b}); end
    wait_px(XS+HA-1, YS);
    compared++;
    if ({a_r, a_g, a_b} !== 24'h000000) begin mismatched++; $display("FAIL bar_last got=%h expected=000000", {a_r, a_g, a_b}); end
  endtask

  task automatic test_crosshatch();
    pattern_sel = 2'd2;
    wait_px(0, 0);
    wait_px(XS, YS+1);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL grid_x0 got=%h expected=ffffff", {a_r, a_g, a_b}); end
    wait_px(XS+1, YS+1);
    compared++;
    if ({a_r, a_g, a_b} !== 24'h000000) begin mismatched++; $display("FAIL grid_off got=%h expected=000000", {a_r, a_g, a_b}); end
    wait_px(XS+HA-1, YS+1);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL grid_right got=%h expected=ffffff", {a_r, a_g, a_b}); end
    wait_px(XS+1, YS+VA-1);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL grid_bottom got=%h expected=ffffff", {a_r, a_g, a_b}); end
    pattern_sel = 2'd3;
    wait_px(0, 0);
    wait_px(XS+5, YS+5);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL solid_white got=%h expected=ffffff", {a_r, a_g, a_b}); end
  endtask

  task automatic test_lag_flash();
    logic [23:0] want;
    pattern_sel = 2'd0; lt_active = 1'b1; lt_mode = 2'd2;
    wait_px(0, 0);
    wait_px(XS+21, YS+15);
    compared++;
    if ({a_r, a_g, a_b} !== 24'h000000) begin mismatched++; $display("FAIL box_left_out got=%h expected=000000", {a_r, a_g, a_b}); end
    wait_px(XS+22, YS+15);
    compared++;
    if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL box_left_in got=%h expected=ffffff", {a_r, a_g, a_b}); end
    for (int f = 0; f < 6; f++) begin
      wait_px(XS+32, YS+20);
      want = (f == 2 || f == 3) ? 24'h000000 : 24'hffffff;
      compared++;
      if ({a_r, a_g, a_b} !== want) begin
        mismatched++; $display("FAIL flash_frame%0d got=%h expected=%h", f, {a_r, a_g, a_b}, want);
      end
      if (f == 0) begin
        wait_px(XS+41, YS+24);
        compared++;
        if ({a_r, a_g, a_b} !== 24'hffffff) begin mismatched++; $display("FAIL box_right_in got=%h expected=ffffff", {a_r, a_g, a_b}); end
        wait_px(XS+42, YS+24);
        compared++;
        if ({a_r, a_g, a_b} !== 24'h000000) begin mismatched++; $display("FAIL box_right_out got=%h expected=000000", {a_r, a_g, a_b}); end
        wait_px(XS+22, YS+25);
        compared++;
        if ({a_r, a_g, a_b} !== 24'h000000) begin mismatched++; $display("FAIL box_below got=%h expected=000000", {a_r, a_g, a_b}); end
      end
    end
    lt_mode = 2'd3;
    wait_px(0, 0);
    lt_active = 1'b0; lt_mode = 2'd1;
    wait_px(XS, YS+VA-1);
  endtask

  task automatic test_reset_midframe();
    pattern_sel = 2'd3;
    wait_px(XS+30, YS+20);
    reset_n = 1'b0;
    #1;
    compared++;
    if ({a_hs, a_vs, a_de, a_r, a_g, a_b, a_fs, b_hs, b_vs, b_de, b_r, b_g, b_b, b_fs}
        !== {28'd0, 2'b11, 26'd0}) begin
      mismatched++;
      $display("FAIL midframe_reset got=%h expected=%h",
               {a_hs, a_vs, a_de, a_r, a_g, a_b, a_fs, b_hs, b_vs, b_de, b_r, b_g, b_b, b_fs},
               {28'd0, 2'b11, 26'd0});
    end
    repeat (2) @(negedge clk27);
    reset_n = 1'b1;
    model_reset();
    wait_px(0, 0);
    compared++;
    if (a_fs !== 1'b1) begin mismatched++; $display("FAIL restart_frame_start got=%b expected=1", a_fs); end
    // latched pattern was cleared, so the first frame is pattern 0 with no scroll
    wait_px(XS+HO, YS+VO);
    compared++;
    if ({a_r, a_g, a_b} !== 24'h747474) begin mismatched++; $display("FAIL restart_ramp got=%h expected=747474", {a_r, a_g, a_b}); end
  endtask

`ifdef VIDEOGEN_SCROLL_EN
  task automatic test_scroll();
    logic [7:0] g;
    pattern_sel = 2'd0;
    for (int f = 1; f <= 3; f++) begin
      wait_px(XS+HO, YS+VO);
      g = 8'h74 + 8'(f);
      compared++;
      if ({a_r, a_g, a_b} !== {g, g, g}) begin
        mismatched++; $display("FAIL scroll_frame%0d got=%h expected=%h", f, {a_r, a_g, a_b}, {g, g, g});
      end
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    pattern_sel = 0; lt_active = 0; lt_mode = 0;
    model_reset();
    test_reset();
    test_sync_timing();
    test_ramp_border();
    test_switch_bars();
    test_crosshatch();
    test_lag_flash();
    test_reset_midframe();
`ifdef VIDEOGEN_SCROLL_EN
    test_scroll();
`endif
    repeat (20) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
